load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store sequencer between the EX/MEM pipeline register and the byte-wide data memory.
//  Converts one RV64 load/store (b/h/w/d, signed/unsigned) into N single-byte memory cycles,
//  stalling the pipeline meanwhile, then returns the sign/zero-extended 64-bit load result.
//  Detects out-of-range (and optionally misaligned) accesses and reports a fault instead of accessing memory.
// PARAMETERS
//  MEM_BYTES  64  size of attached data memory in bytes; valid byte addresses 0..MEM_BYTES-1
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  reset       in   1   asynchronous, active-low reset
//  req_valid   in   1   EX/MEM holds a load or store; held stable while stall=1
//  req_write   in   1   1=store, 0=load
//  funct3      in   3   RISC-V funct3: [1:0] size (0=B,1=H,2=W,3=D), [2] unsigned (loads only)
//  addr        in   64  byte address (ALU result)
//  wdata       in   64  store data (rs2); low 8*N bits used
//  stall       out  1   freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//  done        out  1   one-cycle pulse: access complete, rdata/fault valid
//  rdata       out  64  extended load result; held until next done
//  fault       out  1   with done: access rejected, no memory cycles issued
//  mem_addr    out  64  byte address to data memory
//  mem_wdata   out  8   byte to write
//  mem_we      out  1   write strobe (memory writes on rising clk)
//  mem_re      out  1   read strobe
//  mem_rdata   in   8   combinational read byte for mem_addr
// BEHAVIOUR
//  - N = 1<<funct3[1:0]. States: IDLE, XFER, DONE.
//  - IDLE: req_valid=1 -> stall=1; latch addr/wdata/funct3/req_write; idx<=0; ->XFER, or ->DONE with fault if rejected.
//  - XFER: stall=1; mem_addr=base+idx (64-bit add, modulo 2^64); store: mem_we=1, mem_wdata=wdata[8*idx+:8];
//    load: mem_re=1, buf[8*idx+:8]<=mem_rdata; idx==N-1 -> DONE else idx+1. mem_we/mem_re are 0 outside XFER.
//  - DONE: stall=0, done=1, fault per latched verdict; load: rdata<=extended buf;
//    store: rdata unchanged; -> IDLE unconditionally (req_valid this cycle is the same instruction, ignored).
//  - Latency: accept + N XFER + DONE = N+2 cycles; stall high N+1 cycles. Rejected access: 2 cycles, stall 1.
//  - Extension: funct3[2]=0 sign-extend from bit 8N-1; funct3[2]=1 zero-extend. ld/ldu identical.
//  - Reject (fault=1, rdata<=0, no mem strobes): addr>=MEM_BYTES or addr>MEM_BYTES-N;
//    store with funct3[2]=1; load funct3=3'b111.
//  - Back-to-back: next request accepted in IDLE cycle after DONE; no bubble beyond that.
//  - Reset asserted (any state, incl. mid-XFER): state=IDLE, idx=0, rdata=0, done=0, fault=0,
//    stall=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0; bytes already stored stay written.
// CONFIGURATION
//  - MISALIGN_TRAP_EN defined: addr not a multiple of N is also rejected (fault=1, no memory cycles).
//  - MISALIGN_TRAP_EN undefined: misaligned accesses performed byte-wise like aligned ones; no fault.
// TESTING
//  Memory preload bytes 0..7 = EB 12 78 4F 48 B6 45 FE; bytes 20..23 = 39 7D A6 05.
//  1. lb@0 -> rdata=FFFFFFFF_FFFFFFEB; lbu@0 -> 00000000_000000EB; each 3 cycles, stall high 2.
//  2. ld@0 -> rdata=FE45B648_4F7812EB after 10 cycles; 8 mem_re pulses, addrs 0..7 in order.
//  3. sw 0xDEADBEEF@16, then lw@16 -> FFFFFFFF_DEADBEEF; ld@16 -> 05A67D39_DEADBEEF.
//  4. ld@60 (MEM_BYTES=64) -> done+fault, rdata=0, no mem_we/mem_re, stall 1 cycle.
//  5. lh@5: macro off -> rdata=00000000_000045B6, fault=0; macro on -> fault=1, no mem_re.
//  6. sd 0x1122334455667788@0, reset asserted after 3rd mem_we -> bytes 0..2 = 88 77 66,
//     byte 3 still 4F; outputs at reset values; next lb@3 -> 00000000_0000004F.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store sequencer between the EX/MEM pipeline
// register and a byte-wide data memory. One RV64 load/store (b/h/w/d, signed or
// unsigned) becomes N = 1<<funct3[1:0] single-byte memory cycles, with the
// pipeline stalled meanwhile. Loads return a sign/zero-extended 64-bit result.
// Out-of-range or illegal accesses fault without touching memory.
//
// Optional feature: define MISALIGN_TRAP_EN to also reject accesses whose
// address is not a multiple of N. Undefined, misaligned accesses run byte-wise.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid, req_write, funct3, addr, wdata : request from EX/MEM (held while stall=1)
//   stall      : freeze upstream pipeline (combinational)
//   done       : one-cycle completion pulse; rdata/fault valid with it
//   rdata      : extended load result, held until the next done
//   fault      : access rejected (with done)
//   mem_addr, mem_wdata, mem_we, mem_re : byte memory request
//   mem_rdata  : combinational read byte for mem_addr
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        fault,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [2:0]  f3_q;
  logic        write_q;
  logic [63:0] wdata_q;
  logic [63:0] buf_q;

  logic [3:0]  req_n;
  logic        reject_c;
  logic [2:0]  last_idx;
  logic [63:0] buf_merged;
  logic [5:0]  next_bit;

  // Accept-time verdict; 65-bit sum so the range check cannot wrap.
  always_comb begin
    req_n    = 4'd1 << funct3[1:0];
    reject_c = (({1'b0, addr} + 65'(req_n)) > 65'(MEM_BYTES))
             || (req_write && funct3[2])
             || (!req_write && (funct3 == 3'b111));
`ifdef MISALIGN_TRAP_EN
    if ((addr & 64'(req_n - 4'd1)) != 64'd0) reject_c = 1'b1;
`endif
  end

  // Load buffer with the byte arriving this cycle merged in, so the final
  // byte can be extended straight into rdata on the last transfer.
  always_comb begin
    buf_merged                     = buf_q;
    buf_merged[{idx, 3'b000} +: 8] = mem_rdata;
  end

  assign last_idx = 3'((4'd1 << f3_q[1:0]) - 4'd1);
  assign next_bit = {idx + 3'd1, 3'b000};

  // Stall covers the accept cycle, so it cannot be registered.
  assign stall = reset && (((state == S_IDLE) && req_valid) || (state == S_XFER));

  function automatic logic [63:0] extend(input logic [63:0] v, input logic [2:0] f3);
    logic [63:0] r;
    case (f3[1:0])
      2'd0:    r = f3[2] ? {56'd0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
      2'd1:    r = f3[2] ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
      2'd2:    r = f3[2] ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Sequencer; memory strobes/address are set up one transition ahead so
  // they are registered yet valid throughout each XFER cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= 3'd0;
      f3_q      <= 3'd0;
      write_q   <= 1'b0;
      wdata_q   <= 64'd0;
      buf_q     <= 64'd0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 64'd0;
      mem_addr  <= 64'd0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            f3_q    <= funct3;
            write_q <= req_write;
            wdata_q <= wdata;
            idx     <= 3'd0;
            if (reject_c) begin
              state <= S_DONE;
              done  <= 1'b1;
              fault <= 1'b1;
              rdata <= 64'd0;
            end else begin
              state     <= S_XFER;
              mem_addr  <= addr;
              mem_we    <= req_write;
              mem_re    <= !req_write;
              mem_wdata <= req_write ? wdata[7:0] : 8'd0;
            end
          end
        end
        S_XFER: begin
          if (!write_q) buf_q <= buf_merged;
          if (idx == last_idx) begin
            state  <= S_DONE;
            done   <= 1'b1;
            fault  <= 1'b0;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (!write_q) rdata <= extend(buf_merged, f3_q);
          end else begin
            idx       <= idx + 3'd1;
            mem_addr  <= mem_addr + 64'd1;
            mem_wdata <= wdata_q[next_bit +: 8];
          end
        end
        default: begin
          // DONE: the request still on the inputs is the finished one.
          state <= S_IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
        end
      endcase
    end
  end

endmodule
